// File: rtl/ppx_generator_mc_pkg.sv
// Shared constants for the multi-channel pulse-per-X generator: defaults and
// field slots of the packed {period, high, phase} config word.
package ppx_generator_mc_pkg;

    localparam int          CNT_W_DEF    = 32;
    localparam int unsigned CLK_FREQ_DEF = 32'd10_000_000;

    // Slot indices into a [CFG_FIELDS-1:0][CNT_W-1:0] config word
    localparam int CFG_PHASE  = 0;
    localparam int CFG_HIGH   = 1;
    localparam int CFG_PERIOD = 2;
    localparam int CFG_FIELDS = 3;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppx_generator_mc_if.sv
// Control / config / pulse bus of ppx_generator_mc; master drives, slave is the block.
interface ppx_generator_mc_if
    import ppx_generator_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
) ();
    localparam int CH_W = ch_w(NUM_CH);

    logic              enable;
    logic              sync_in;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ppx;
    logic [NUM_CH-1:0] ppx_edge;
    logic [NUM_CH-1:0] cfg_pending;

    modport master (
        output enable, sync_in, cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_phase,
        input  ppx, ppx_edge, cfg_pending
    );

    modport slave (
        input  enable, sync_in, cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_phase,
        output ppx, ppx_edge, cfg_pending
    );

endinterface

// File: rtl/ppx_generator_mc_channel.sv
// One pulse channel: period counter, double-buffered config, window compare and
// registered pulse / rising-edge outputs.
module ppx_generator_mc_channel
    import ppx_generator_mc_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] CLK_FREQ = CNT_W'(CLK_FREQ_DEF)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                sync_in,
    input  logic                                wr,
    input  logic [CFG_FIELDS-1:0][CNT_W-1:0]    wr_cfg,
    output logic                                ppx,
    output logic                                ppx_edge,
    output logic                                pending
);

    logic [CNT_W-1:0]                 count_q, count_d;
    logic [CFG_FIELDS-1:0][CNT_W-1:0] shad_q, shad_d;
    logic [CFG_FIELDS-1:0][CNT_W-1:0] act_q, act_d;
    logic                             pending_q, pending_d;
    logic                             ppx_q, ppx_d;
    logic                             edge_q, edge_d;

    logic [CNT_W-1:0] per, ph, hi;
    logic [CNT_W:0]   win_end;
    logic             win, last, apply;

    // Window decode; end is one bit wider so ph+H never overflows
    always_comb begin
        per     = (act_q[CFG_PERIOD] == '0) ? CLK_FREQ : act_q[CFG_PERIOD];
        hi      = act_q[CFG_HIGH];
        ph      = (act_q[CFG_PHASE] >= per) ? '0 : act_q[CFG_PHASE];
        win_end = {1'b0, ph} + {1'b0, hi};
        if (hi == '0)
            win = (count_q == ph);
        else if (hi >= per)
            win = 1'b1;
        else if (win_end > {1'b0, per})
            win = (count_q >= ph) || ({1'b0, count_q} < (win_end - {1'b0, per}));
        else
            win = (count_q >= ph) && ({1'b0, count_q} < win_end);
        last  = (count_q == per - CNT_W'(1));
        apply = !enable || sync_in || last;
    end

    always_comb begin
        count_d   = count_q;
        shad_d    = shad_q;
        act_d     = act_q;
        pending_d = pending_q;
        ppx_d     = enable & win;
        edge_d    = enable & win & ~ppx_q;
        count_d   = apply ? '0 : count_q + CNT_W'(1);
        if (apply) begin
            act_d     = shad_q;
            pending_d = 1'b0;
        end
        // A write on an apply cycle lands after the old shadow has been taken
        if (wr) begin
            shad_d    = wr_cfg;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            shad_q    <= '0;
            act_q     <= '0;
            pending_q <= 1'b0;
            ppx_q     <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            shad_q    <= shad_d;
            act_q     <= act_d;
            pending_q <= pending_d;
            ppx_q     <= ppx_d;
            edge_q    <= edge_d;
        end
    end

    assign ppx      = ppx_q;
    assign ppx_edge = edge_q;
    assign pending  = pending_q;

endmodule

// File: rtl/ppx_generator_mc.sv
// Multi-channel pulse-per-X generator: decodes config writes to channels and
// fans out the common enable / sync strobes.
module ppx_generator_mc
    import ppx_generator_mc_pkg::*;
#(
    parameter int               NUM_CH   = 4,
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] CLK_FREQ = CNT_W'(CLK_FREQ_DEF)
) (
    input  logic               clk,
    input  logic               reset_n,
    ppx_generator_mc_if.slave  bus
);

    localparam int CH_W = ch_w(NUM_CH);

    logic [CFG_FIELDS-1:0][CNT_W-1:0] wr_cfg;
    logic [NUM_CH-1:0]                ppx_w, edge_w, pend_w;

    assign wr_cfg[CFG_PERIOD] = bus.cfg_period;
    assign wr_cfg[CFG_HIGH]   = bus.cfg_high;
    assign wr_cfg[CFG_PHASE]  = bus.cfg_phase;

    // Out-of-range cfg_ch matches no channel, so the write is dropped
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ppx_generator_mc_channel #(
            .CNT_W    (CNT_W),
            .CLK_FREQ (CLK_FREQ)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (bus.enable),
            .sync_in  (bus.sync_in),
            .wr       (bus.cfg_wr && (bus.cfg_ch == CH_W'(i))),
            .wr_cfg   (wr_cfg),
            .ppx      (ppx_w[i]),
            .ppx_edge (edge_w[i]),
            .pending  (pend_w[i])
        );
    end

    assign bus.ppx         = ppx_w;
    assign bus.ppx_edge    = edge_w;
    assign bus.cfg_pending = pend_w;

endmodule

// File: tb/tb_ppx_generator_mc.sv
// Bench for ppx_generator_mc: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural channel model.
module tb_ppx_generator_mc;

    localparam int NCH = 5;
    localparam int CW  = 16;
    localparam int CF  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   run   = 1'b0;
    int   ncmp  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    ppx_generator_mc_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    ppx_generator_mc #(.NUM_CH(NCH), .CNT_W(CW), .CLK_FREQ(16'(CF))) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // ---------------- behavioural model ----------------
    int a_per[NCH], a_hi[NCH], a_ph[NCH];
    int s_per[NCH], s_hi[NCH], s_ph[NCH];
    int cnt[NCH];
    bit pend[NCH], m_ppx[NCH], m_edge[NCH];

    // High iff the distance from phase start (mod period) is inside the width
    function automatic bit in_win(int c, int per, int hi, int ph);
        int p, s;
        p = (per == 0) ? CF : per;
        s = (ph >= p) ? 0 : ph;
        if (hi >= p) return 1'b1;
        return ((c - s + p) % p) < ((hi == 0) ? 1 : hi);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                a_per[c] = 0; a_hi[c] = 0; a_ph[c] = 0;
                s_per[c] = 0; s_hi[c] = 0; s_ph[c] = 0;
                cnt[c] = 0; pend[c] = 0; m_ppx[c] = 0; m_edge[c] = 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                int p;
                bit w, ap;
                p  = (a_per[c] == 0) ? CF : a_per[c];
                w  = in_win(cnt[c], a_per[c], a_hi[c], a_ph[c]);
                m_edge[c] = bus.enable && w && !m_ppx[c];
                m_ppx[c]  = bus.enable && w;
                ap = !bus.enable || bus.sync_in || (cnt[c] == p - 1);
                cnt[c] = ap ? 0 : cnt[c] + 1;
                if (ap) begin
                    a_per[c] = s_per[c]; a_hi[c] = s_hi[c]; a_ph[c] = s_ph[c];
                    pend[c] = 0;
                end
                if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
                    s_per[c] = int'(bus.cfg_period);
                    s_hi[c]  = int'(bus.cfg_high);
                    s_ph[c]  = int'(bus.cfg_phase);
                    pend[c]  = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            logic [NCH-1:0] ep, ee, epd;
            for (int c = 0; c < NCH; c++) begin
                ep[c] = m_ppx[c]; ee[c] = m_edge[c]; epd[c] = pend[c];
            end
            chk("model_ppx", int'(bus.ppx), int'(ep));
            chk("model_edge", int'(bus.ppx_edge), int'(ee));
            chk("model_pending", int'(bus.cfg_pending), int'(epd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int per, input int hi, input int ph);
        bus.cfg_ch = 3'(ch); bus.cfg_period = 16'(per);
        bus.cfg_high = 16'(hi); bus.cfg_phase = 16'(ph);
        bus.cfg_wr = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic pulse_sync();
        bus.sync_in = 1'b1;
        tick();
        bus.sync_in = 1'b0;
    endtask

    task automatic wait_cnt(input int ch, input int v);
        int n = 0;
        while (cnt[ch] != v && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            ncmp++; nfail++;
            $display("FAIL wait_cnt ch%0d: count never reached %0d", ch, v);
        end
    endtask

    initial begin
        logic [NCH-1:0] pv;
        int ne;
        bus.enable = 0; bus.sync_in = 0; bus.cfg_wr = 0; bus.cfg_ch = '0;
        bus.cfg_period = '0; bus.cfg_high = '0; bus.cfg_phase = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        chk("reset_ppx", int'(bus.ppx), 0);
        chk("reset_edge", int'(bus.ppx_edge), 0);
        chk("reset_pending", int'(bus.cfg_pending), 0);

        // Default config: 1-cycle pulse every CF clocks, edge coincident
        bus.enable = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            chk("t1_ppx0", int'(bus.ppx[0]), int'(k % 10 == 0));
            chk("t1_edge0", int'(bus.ppx_edge[0]), int'(k % 10 == 0));
        end

        // ch1 8/2/3 then the wrapping window 8/4/6
        cfg_write(1, 8, 2, 3);
        pulse_sync();
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t2_win", int'(bus.ppx[1]), int'(((k - 1) % 8) inside {3, 4}));
        end
        cfg_write(1, 8, 4, 6);
        pulse_sync();
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t2_wrapwin", int'(bus.ppx[1]), int'(((k - 1) % 8) inside {6, 7, 0, 1}));
        end

        // ch2 period 20 written mid-period of 10
        wait_cnt(2, 3);
        cfg_write(2, 20, 0, 0);
        chk("t3_pend_set", int'(bus.cfg_pending[2]), 1);
        repeat (5) tick();
        chk("t3_pend_hold", int'(bus.cfg_pending[2]), 1);
        tick();
        chk("t3_pend_clear", int'(bus.cfg_pending[2]), 0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk("t3_per20", int'(bus.ppx[2]), int'(k == 1 || k == 21));
        end
        // Write on the wrap cycle: stays pending for one more period
        wait_cnt(2, 19);
        cfg_write(2, 12, 0, 0);
        chk("t3_wrapwr_pend", int'(bus.cfg_pending[2]), 1);
        repeat (19) tick();
        chk("t3_wrapwr_hold", int'(bus.cfg_pending[2]), 1);
        tick();
        chk("t3_wrapwr_apply", int'(bus.cfg_pending[2]), 0);

        // sync at an arbitrary point realigns every channel
        repeat ($urandom_range(1, 15)) tick();
        pulse_sync();
        tick();
        chk("t4_sync_k1", int'(bus.ppx), 5'b11111);
        tick();
        chk("t4_sync_k2", int'(bus.ppx), 5'b00010);

        // ch3 high==period: constant high, one edge
        cfg_write(3, 10, 10, 0);
        pulse_sync();
        ne = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t5_const", int'(bus.ppx[3]), 1);
            ne += int'(bus.ppx_edge[3]);
        end
        chk("t5_one_edge", ne, 1);
        // ch4 phase beyond period -> treated as 0
        cfg_write(4, 10, 0, 12);
        pulse_sync();
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t5_phase_oob", int'(bus.ppx[4]), int'(k == 1 || k == 11));
        end
        // out-of-range channel writes are dropped
        pv = bus.cfg_pending;
        cfg_write(5, 3, 1, 1);
        cfg_write(7, 4, 1, 1);
        chk("t5_bad_ch", int'(bus.cfg_pending), int'(pv));

        // enable drop mid-pulse clears synchronously
        bus.enable = 1'b0;
        tick();
        chk("t6_dis_ppx", int'(bus.ppx), 0);
        cfg_write(0, 5, 0, 0);
        tick();
        bus.enable = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk("t6_reen", int'(bus.ppx[0]), int'(k == 0 || k == 5));
        end
        // async reset mid-pulse
        chk("t6_pre_rst", int'(bus.ppx[3]), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ppx", int'(bus.ppx), 0);
        chk("t6_rst_pend", int'(bus.cfg_pending), 0);
        bus.enable = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("t6_post_rst", int'(bus.ppx), 0);
        end
        bus.enable = 1'b1;

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 1500; i++) begin
            bus.sync_in = ($urandom_range(0, 49) == 0);
            bus.cfg_wr  = ($urandom_range(0, 5) == 0);
            bus.cfg_ch  = 3'($urandom_range(0, 7));
            bus.cfg_period = 16'($urandom_range(0, 25));
            bus.cfg_high   = 16'($urandom_range(0, 27));
            bus.cfg_phase  = 16'($urandom_range(0, 27));
            if (bus.enable) bus.enable = ($urandom_range(0, 39) != 0);
            else            bus.enable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        bus.cfg_wr = 0; bus.sync_in = 0;
        tick();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
